// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: access encodings,
// line geometry and the byte-lane mask / alignment functions.
package dmem_pkg;

  localparam int LINE_BYTES  = 8;
  localparam int LINE_OFFSET = 3;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  // Bit layout matches the core's 4-bit op: [3] store, [2] unsigned, [1:0] size.
  typedef struct packed {
    logic  store;
    logic  uns;
    size_e size;
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [LINE_BYTES-1:0] size_mask(input size_e size);
    case (size)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [LINE_OFFSET-1:0] offset,
                                         input size_e size);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return offset[0];
      SIZE_W:  return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 64-bit SRAM bank with per-byte write enables and a synchronous,
// enable-gated read whose output register holds until the next read.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LINE_BYTES-1:0] be,
  input  logic [AW-1:0]         waddr,
  input  logic [63:0]           wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [63:0]           rdata
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  // Read data is captured only on re, so later writes to the same line
  // cannot disturb a response that is still waiting to go out.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (be[i]) mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller for the scalar core: valid/ready request, optional wait
// states, one-shot registered response, byte-masked stores and extended loads.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 40,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [ADDR_W-1:0]        req_addr_i,
  input  logic [3:0]               req_op_i,
  input  logic [63:0]              req_wdata_i,
  output logic                     resp_valid_o,
  output logic [63:0]              resp_data_o,
  output logic                     resp_misaligned_o,
  output logic [ADDR_W-1:0]        resp_addr_o,
  input  logic                     dbg_we_i,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
  input  logic [63:0]              dbg_data_i
);

  localparam int         LINE_W    = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  mem_op_t             op_q, op_d;
  logic [63:0]         rsp_data_q, rsp_data_d;
  logic                rsp_mis_q, rsp_mis_d;
  logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;

  mem_op_t                req_op;
  logic [LINE_OFFSET-1:0] req_off;
  logic [LINE_W-1:0]      req_line;
  logic                   req_mis;
  logic                   accept;
  logic                   unused_addr_hi;

  assign req_op         = mem_op_t'(req_op_i);
  assign req_off        = req_addr_i[LINE_OFFSET-1:0];
  assign req_line       = req_addr_i[LINE_W+LINE_OFFSET-1:LINE_OFFSET];
  assign req_mis        = is_misaligned(req_off, req_op.size);
  assign unused_addr_hi = ^req_addr_i[ADDR_W-1:LINE_W+LINE_OFFSET];

  assign req_ready_o = (state_q == ST_IDLE) & ~dbg_we_i & ~arst;
  assign accept      = req_valid_i & req_ready_o;

  logic                  bank_we;
  logic [LINE_BYTES-1:0] bank_be;
  logic [LINE_W-1:0]     bank_waddr;
  logic [63:0]           bank_wdata;
  logic [63:0]           bank_rdata;

  // Debugger owns the write port whenever it asks; it also blocks acceptance,
  // so a CPU store never competes for the port in the same cycle.
  always_comb begin
    bank_we    = dbg_we_i | (accept & req_op.store & ~req_mis);
    bank_be    = size_mask(req_op.size) << req_off;
    bank_waddr = req_line;
    bank_wdata = req_wdata_i << {req_off, 3'b000};
    if (dbg_we_i) begin
      bank_be    = '1;
      bank_waddr = dbg_addr_i;
      bank_wdata = dbg_data_i;
    end
  end

  dmem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .be    (bank_be),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .re    (accept),
    .raddr (req_line),
    .rdata (bank_rdata)
  );

  logic [63:0] shifted;
  logic [63:0] load_data;
  logic        cur_mis;
  logic [63:0] cur_data;

  always_comb begin
    shifted = bank_rdata >> {addr_q[LINE_OFFSET-1:0], 3'b000};
    case (op_q.size)
      SIZE_B:  load_data = {{56{shifted[7]  & ~op_q.uns}}, shifted[7:0]};
      SIZE_H:  load_data = {{48{shifted[15] & ~op_q.uns}}, shifted[15:0]};
      SIZE_W:  load_data = {{32{shifted[31] & ~op_q.uns}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
    cur_mis  = is_misaligned(addr_q[LINE_OFFSET-1:0], op_q.size);
    cur_data = (op_q.store | cur_mis) ? 64'd0 : load_data;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_mis_d  = rsp_mis_q;
    rsp_addr_d = rsp_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          op_d    = req_op;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        rsp_data_d = cur_data;
        rsp_mis_d  = cur_mis;
        rsp_addr_d = addr_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      op_q       <= mem_op_t'('0);
      rsp_data_q <= '0;
      rsp_mis_q  <= 1'b0;
      rsp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_mis_q  <= rsp_mis_d;
      rsp_addr_q <= rsp_addr_d;
    end
  end

  // Live values during RESP, then the captured copy holds until the next one.
  assign resp_valid_o      = (state_q == ST_RESP);
  assign resp_data_o       = resp_valid_o ? cur_data : rsp_data_q;
  assign resp_misaligned_o = resp_valid_o ? cur_mis  : rsp_mis_q;
  assign resp_addr_o       = resp_valid_o ? addr_q   : rsp_addr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench: two controllers (0 and 3 wait states) driven from
// scenario tasks, expectations from a byte-wise memory model via a scoreboard.
module tb_dmem_ctrl;

  localparam logic [3:0] OP_LB = 4'b0000, OP_LH = 4'b0001, OP_LW = 4'b0010, OP_LD = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100, OP_LWU = 4'b0110;
  localparam logic [3:0] OP_SB = 4'b1000, OP_SH = 4'b1001, OP_SW = 4'b1010, OP_SD = 4'b1011;

  typedef struct {
    logic [63:0] data;
    logic        mis;
    logic [39:0] addr;
  } exp_t;

  logic        clk;
  logic        arst      [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [39:0] req_addr  [2];
  logic [3:0]  req_op    [2];
  logic [63:0] req_wdata [2];
  logic        resp_valid[2];
  logic [63:0] resp_data [2];
  logic        resp_mis  [2];
  logic [39:0] resp_addr [2];
  logic        dbg_we    [2];
  logic [10:0] dbg_addr  [2];
  logic [63:0] dbg_data  [2];

  int          ws [2] = '{0, 3};
  logic [63:0] mdl [2][2048];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  dmem_ctrl #(.ADDR_W(40), .DEPTH(2048), .WAIT_STATES(0)) dut0 (
    .clk(clk), .arst(arst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr[0]), .req_op_i(req_op[0]), .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_data_o(resp_data[0]),
    .resp_misaligned_o(resp_mis[0]), .resp_addr_o(resp_addr[0]),
    .dbg_we_i(dbg_we[0]), .dbg_addr_i(dbg_addr[0]), .dbg_data_i(dbg_data[0])
  );

  dmem_ctrl #(.ADDR_W(40), .DEPTH(2048), .WAIT_STATES(3)) dut1 (
    .clk(clk), .arst(arst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr[1]), .req_op_i(req_op[1]), .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_data_o(resp_data[1]),
    .resp_misaligned_o(resp_mis[1]), .resp_addr_o(resp_addr[1]),
    .dbg_we_i(dbg_we[1]), .dbg_addr_i(dbg_addr[1]), .dbg_data_i(dbg_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory: stores update it byte by byte, loads gather and extend.
  task automatic model_req(input int d, input logic [3:0] op, input logic [39:0] addr,
                           input logic [63:0] wd, output exp_t e);
    int nb, off, ln;
    nb = 1 << op[1:0];
    off = int'(addr[2:0]);
    ln = int'(addr[13:3]);
    e.data = '0;
    e.addr = addr;
    e.mis = (off % nb) != 0;
    if (!e.mis) begin
      if (op[3]) begin
        for (int i = 0; i < nb; i++) mdl[d][ln][(off+i)*8 +: 8] = wd[i*8 +: 8];
      end else begin
        for (int i = 0; i < nb; i++) e.data[i*8 +: 8] = mdl[d][ln][(off+i)*8 +: 8];
        if (!op[2] && nb < 8 && e.data[nb*8-1])
          for (int i = nb*8; i < 64; i++) e.data[i] = 1'b1;
      end
    end
  endtask

  // Issue one request, push its expectation, and wait for the response.
  // dbg_at > 0 pulses a debugger write that many cycles after acceptance.
  task automatic do_req(input int d, input logic [3:0] op, input logic [39:0] addr,
                        input logic [63:0] wd, input int dbg_at, input logic [10:0] dl,
                        input logic [63:0] dd, output logic [63:0] o_data, output logic o_mis,
                        output logic [39:0] o_addr, output int o_lat, output logic o_rdy);
    exp_t e;
    int   guard;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_op[d]    = op;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    guard = 0;
    #1;
    while (!req_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    model_req(d, op, addr, wd, e);
    sb.push_back(e);
    @(negedge clk);
    req_valid[d] = 1'b0;
    o_lat = 1;
    while (!resp_valid[d] && o_lat < 50) begin
      if (o_lat == dbg_at) begin
        dbg_we[d] = 1'b1;
        dbg_addr[d] = dl;
        dbg_data[d] = dd;
        mdl[d][dl] = dd;
      end
      @(negedge clk);
      dbg_we[d] = 1'b0;
      o_lat++;
    end
    o_data = resp_data[d];
    o_mis  = resp_mis[d];
    o_addr = resp_addr[d];
    o_rdy  = req_ready[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      arst[d] = 1'b1; req_valid[d] = 1'b1; req_addr[d] = '0; req_op[d] = OP_LD;
      req_wdata[d] = '0; dbg_we[d] = 1'b0; dbg_addr[d] = '0; dbg_data[d] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (req_ready[d] !== 1'b0) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 0", d, req_ready[d]); end
      n_cmp++; if (resp_valid[d] !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b want 0", d, resp_valid[d]); end
      n_cmp++; if (resp_data[d] !== 64'd0) begin n_bad++; $display("FAIL reset_data[%0d]: got %h want 0", d, resp_data[d]); end
      n_cmp++; if (resp_mis[d] !== 1'b0) begin n_bad++; $display("FAIL reset_mis[%0d]: got %b want 0", d, resp_mis[d]); end
      n_cmp++; if (resp_addr[d] !== 40'd0) begin n_bad++; $display("FAIL reset_addr[%0d]: got %h want 0", d, resp_addr[d]); end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin arst[d] = 1'b0; req_valid[d] = 1'b0; end
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (req_ready[d] !== 1'b1) begin n_bad++; $display("FAIL release_ready[%0d]: got %b want 1", d, req_ready[d]); end
    end
  endtask

  task automatic test_store_load();
    logic [3:0]  ops [10] = '{OP_SD, OP_LD, OP_SB, OP_LD, OP_LB, OP_LBU, OP_LH, OP_LWU, OP_SW, OP_LW};
    logic [39:0] ads [10] = '{40'h100, 40'h100, 40'h103, 40'h100, 40'h103, 40'h103,
                              40'h102, 40'h104, 40'h10C, 40'h10C};
    logic [63:0] wds [10] = '{64'h1122334455667788, 64'h0, 64'h00000000000000AA, 64'h0, 64'h0,
                              64'h0, 64'h0, 64'h0, 64'h00000000CAFEF00D, 64'h0};
    logic [63:0] od; logic om, ordy; logic [39:0] oa; int ol; exp_t e;
    for (int i = 0; i < 10; i++) begin
      do_req(0, ops[i], ads[i], wds[i], 0, '0, '0, od, om, oa, ol, ordy);
      e = sb.pop_front();
      n_cmp++; if (od !== e.data) begin n_bad++; $display("FAIL store_load[%0d] data: got %h want %h", i, od, e.data); end
      n_cmp++; if (om !== e.mis) begin n_bad++; $display("FAIL store_load[%0d] mis: got %b want %b", i, om, e.mis); end
      n_cmp++; if (oa !== e.addr) begin n_bad++; $display("FAIL store_load[%0d] addr: got %h want %h", i, oa, e.addr); end
      n_cmp++; if (ol != 1 + ws[0]) begin n_bad++; $display("FAIL store_load[%0d] latency: got %0d want %0d", i, ol, 1 + ws[0]); end
      n_cmp++; if (ordy !== 1'b0) begin n_bad++; $display("FAIL store_load[%0d] ready_in_resp: got %b want 0", i, ordy); end
    end
  endtask

  task automatic test_misaligned();
    logic [3:0]  ops [6] = '{OP_LW, OP_SH, OP_SD, OP_LH, OP_SW, OP_LD};
    logic [39:0] ads [6] = '{40'h102, 40'h101, 40'h105, 40'h107, 40'h10E, 40'h100};
    logic [63:0] wds [6] = '{64'h0, 64'hBEEF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h12345678, 64'h0};
    logic [63:0] od; logic om, ordy; logic [39:0] oa; int ol; exp_t e;
    for (int i = 0; i < 6; i++) begin
      do_req(0, ops[i], ads[i], wds[i], 0, '0, '0, od, om, oa, ol, ordy);
      e = sb.pop_front();
      n_cmp++; if (od !== e.data) begin n_bad++; $display("FAIL misaligned[%0d] data: got %h want %h", i, od, e.data); end
      n_cmp++; if (om !== e.mis) begin n_bad++; $display("FAIL misaligned[%0d] mis: got %b want %b", i, om, e.mis); end
      n_cmp++; if (ol != 1 + ws[0]) begin n_bad++; $display("FAIL misaligned[%0d] latency: got %0d want %0d", i, ol, 1 + ws[0]); end
    end
  endtask

  task automatic test_debug();
    logic [3:0]  ops [4] = '{OP_LD, OP_LD, OP_LWU, OP_LB};
    logic [39:0] ads [4] = '{40'h100, 40'h4100, 40'h4100, 40'h4101};
    logic [63:0] od; logic om, ordy; logic [39:0] oa; int ol; exp_t e;
    @(negedge clk);
    dbg_we[0] = 1'b1; dbg_addr[0] = 11'h020; dbg_data[0] = 64'hDEAD;
    req_valid[0] = 1'b1; req_op[0] = OP_LD; req_addr[0] = 40'h100;
    #1;
    n_cmp++; if (req_ready[0] !== 1'b0) begin n_bad++; $display("FAIL dbg_blocks_ready: got %b want 0", req_ready[0]); end
    @(negedge clk);
    mdl[0][11'h020] = 64'hDEAD;
    n_cmp++; if (resp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL dbg_no_accept: got %b want 0", resp_valid[0]); end
    dbg_we[0] = 1'b0; req_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_req(0, ops[i], ads[i], 64'h0, 0, '0, '0, od, om, oa, ol, ordy);
      e = sb.pop_front();
      n_cmp++; if (od !== e.data) begin n_bad++; $display("FAIL debug[%0d] data: got %h want %h", i, od, e.data); end
      n_cmp++; if (oa !== e.addr) begin n_bad++; $display("FAIL debug[%0d] addr: got %h want %h", i, oa, e.addr); end
    end
  endtask

  task automatic test_dbg_inflight();
    logic [3:0]  ops [3] = '{OP_SD, OP_LD, OP_LD};
    int          dat [3] = '{0, 2, 0};
    logic [63:0] wds [3] = '{64'h1111111111111111, 64'h0, 64'h0};
    logic [63:0] od; logic om, ordy; logic [39:0] oa; int ol; exp_t e;
    for (int i = 0; i < 3; i++) begin
      do_req(1, ops[i], 40'h300, wds[i], dat[i], 11'h060, 64'h2222222222222222, od, om, oa, ol, ordy);
      e = sb.pop_front();
      n_cmp++; if (od !== e.data) begin n_bad++; $display("FAIL dbg_inflight[%0d] data: got %h want %h", i, od, e.data); end
      n_cmp++; if (ol != 1 + ws[1]) begin n_bad++; $display("FAIL dbg_inflight[%0d] latency: got %0d want %0d", i, ol, 1 + ws[1]); end
    end
  endtask

  task automatic test_wait_states();
    exp_t e1, e2; int guard, lat;
    @(negedge clk);
    req_valid[1] = 1'b1; req_op[1] = OP_LD; req_addr[1] = 40'h300; req_wdata[1] = '0;
    guard = 0;
    #1;
    while (!req_ready[1] && guard < 50) begin @(negedge clk); guard++; end
    model_req(1, OP_LD, 40'h300, 64'h0, e1);
    @(negedge clk);
    req_op[1] = OP_LW; req_addr[1] = 40'h304;
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_cmp++; if (req_ready[1] !== 1'b0) begin n_bad++; $display("FAIL wait_ready[T+%0d]: got %b want 0", k, req_ready[1]); end
      n_cmp++; if (resp_valid[1] !== (k == 4)) begin n_bad++; $display("FAIL wait_valid[T+%0d]: got %b want %b", k, resp_valid[1], k == 4); end
      if (k == 4) begin
        n_cmp++; if (resp_data[1] !== e1.data) begin n_bad++; $display("FAIL wait_data: got %h want %h", resp_data[1], e1.data); end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (req_ready[1] !== 1'b1) begin n_bad++; $display("FAIL wait_ready[T+5]: got %b want 1", req_ready[1]); end
    model_req(1, OP_LW, 40'h304, 64'h0, e2);
    sb.push_back(e2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    lat = 1;
    while (!resp_valid[1] && lat < 50) begin @(negedge clk); lat++; end
    e2 = sb.pop_front();
    n_cmp++; if (lat != 1 + ws[1]) begin n_bad++; $display("FAIL wait_second_latency: got %0d want %0d", lat, 1 + ws[1]); end
    n_cmp++; if (resp_data[1] !== e2.data) begin n_bad++; $display("FAIL wait_second_data: got %h want %h", resp_data[1], e2.data); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] od; logic om, ordy; logic [39:0] oa; int ol, guard; logic pulsed; exp_t e;
    @(negedge clk);
    req_valid[1] = 1'b1; req_op[1] = OP_LD; req_addr[1] = 40'h300;
    guard = 0;
    #1;
    while (!req_ready[1] && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    arst[1] = 1'b1;
    #1;
    n_cmp++; if (resp_valid[1] !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", resp_valid[1]); end
    n_cmp++; if (resp_data[1] !== 64'd0) begin n_bad++; $display("FAIL midrst_data: got %h want 0", resp_data[1]); end
    n_cmp++; if (resp_addr[1] !== 40'd0) begin n_bad++; $display("FAIL midrst_addr: got %h want 0", resp_addr[1]); end
    n_cmp++; if (req_ready[1] !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", req_ready[1]); end
    @(negedge clk);
    arst[1] = 1'b0;
    #1;
    n_cmp++; if (req_ready[1] !== 1'b1) begin n_bad++; $display("FAIL midrst_release_ready: got %b want 1", req_ready[1]); end
    pulsed = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (resp_valid[1] !== 1'b0) pulsed = 1'b1;
    end
    n_cmp++; if (pulsed !== 1'b0) begin n_bad++; $display("FAIL midrst_dropped: got %b want 0", pulsed); end
    do_req(1, OP_LD, 40'h300, 64'h0, 0, '0, '0, od, om, oa, ol, ordy);
    e = sb.pop_front();
    n_cmp++; if (od !== e.data) begin n_bad++; $display("FAIL midrst_after_data: got %h want %h", od, e.data); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_debug();
    test_dbg_inflight();
    test_wait_states();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
